// File: rtl/sram_1rw1r_wmask_model.sv
// Behavioural 1RW + 1R SRAM with per-group write mask and an optional post-reset clear sequencer.
// Port 0 reads/writes, port 1 only reads; both read ports are registered with one cycle of latency.
module sram_1rw1r_wmask_model #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned WMASK_WIDTH    = 4,
    parameter int unsigned CLEAR_ON_RESET = 1,
    parameter int unsigned VERBOSE        = 0
) (
    input  logic                   clk0,
    input  logic                   rst0,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    output logic [DATA_WIDTH-1:0]  dout0,
    input  logic                   csb1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   busy
);

    localparam int unsigned RAM_DEPTH   = 1 << ADDR_WIDTH;
    localparam int unsigned GROUP_WIDTH = DATA_WIDTH / WMASK_WIDTH;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;

    // Reject geometries the mask slicing cannot represent; VERBOSE is a 0/1 switch.
    if ((DATA_WIDTH % WMASK_WIDTH) != 0 || VERBOSE > 1) begin : g_param_check
        $error("sram_1rw1r_wmask_model: illegal parameter combination");
    end

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_next;
    logic                  busy_next;
    logic                  clr_c;
    logic                  wr0_c;
    logic                  rd0_c;
    logic                  rd1_c;

    // Next-state and access decode; ports are only honoured once the clear has finished.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clr_c      = 1'b0;
        wr0_c      = 1'b0;
        rd0_c      = 1'b0;
        rd1_c      = 1'b0;
        case (state)
            ST_INIT: begin
                clr_c    = 1'b1;
                cnt_next = ADDR_WIDTH'(cnt + 1'b1);
                if (cnt == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                wr0_c = !csb0 && !web0;
                rd0_c = !csb0 &&  web0;
                rd1_c = !csb1;
            end
            default: state_next = RESET_STATE;
        endcase
        busy_next = (state_next == ST_INIT);
    end

    // Control state and registered read data.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state <= RESET_STATE;
            cnt   <= '0;
            busy  <= (CLEAR_ON_RESET != 0);
            dout0 <= '0;
            dout1 <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            busy  <= busy_next;
            if (rd0_c) begin
                dout0 <= mem[addr0];
            end
            if (rd1_c) begin
                dout1 <= mem[addr1];
            end
        end
    end

    // Array update; reads above see the pre-write word on a same-edge collision.
    always_ff @(posedge clk0) begin
        if (!rst0) begin
            if (clr_c) begin
                mem[cnt] <= '0;
            end else if (wr0_c) begin
                for (int unsigned i = 0; i < WMASK_WIDTH; i++) begin
                    if (wmask0[i]) begin
                        mem[addr0][i*GROUP_WIDTH +: GROUP_WIDTH] <= din0[i*GROUP_WIDTH +: GROUP_WIDTH];
                    end
                end
            end
        end
    end

endmodule
